// File: rtl/adv7123_vga_driver.sv
// Raster timing generator and pixel driver for the ADV7123 VGA DAC.
// Locks a valid/ready RGB stream to the raster with SOF and blanks to black until the next frame on any slip.
module adv7123_vga_driver #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic        ul1Clock,
  input  logic        ul1Reset_n,
  input  logic        ul1PixValid,
  input  logic [23:0] ul24PixData,
  input  logic        ul1PixSof,
  output logic        ul1PixReady,
  output logic        ul1FrameErr,
  output logic        ul1VgaClock,
  output logic [7:0]  ul8VgaRed,
  output logic [7:0]  ul8VgaGreen,
  output logic [7:0]  ul8VgaBlue,
  output logic        ul1VgaBlank_n,
  output logic        ul1VgaHSync,
  output logic        ul1VgaVSync,
  output logic        ul1VgaSync_n
);

  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic {SYNC_WAIT, RUN} state_e;

  state_e      state_q, state_d;
  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] vcnt_q, vcnt_d;
  logic [23:0] rgb_q, rgb_d;
  logic        blank_n_q, hsync_q, vsync_q, err_q;
  logic        err_d, show;
  logic        active, first_pix, hs_on, vs_on;

  assign active    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign first_pix = (hcnt_q == 12'd0) && (vcnt_q == 12'd0);
  assign hs_on     = (hcnt_q >= HS_START) && (hcnt_q <= HS_END);
  assign vs_on     = (vcnt_q >= VS_START) && (vcnt_q <= VS_END);

  always_comb begin
    hcnt_d = hcnt_q + 12'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? 12'd0 : vcnt_q + 12'd1;
    end
  end

  // A SOF that disagrees with the raster position (either direction) is a slip: refuse it and resync.
  always_comb begin
    state_d     = state_q;
    ul1PixReady = 1'b0;
    show        = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      SYNC_WAIT: begin
        if (ul1PixValid) begin
          if (!ul1PixSof) begin
            ul1PixReady = 1'b1;
          end else if (first_pix) begin
            ul1PixReady = 1'b1;
            show        = 1'b1;
            state_d     = RUN;
          end
        end
      end
      RUN: begin
        ul1PixReady = active;
        if (active && !ul1PixValid) begin
          err_d   = 1'b1;
          state_d = SYNC_WAIT;
        end else if (active && (ul1PixSof != first_pix)) begin
          ul1PixReady = 1'b0;
          err_d       = 1'b1;
          state_d     = SYNC_WAIT;
        end else if (active) begin
          show = 1'b1;
        end
      end
      default: state_d = SYNC_WAIT;
    endcase
  end

  assign rgb_d = show ? ul24PixData : 24'd0;

  always_ff @(posedge ul1Clock or negedge ul1Reset_n) begin
    if (!ul1Reset_n) begin
      state_q   <= SYNC_WAIT;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      rgb_q     <= '0;
      blank_n_q <= 1'b0;
      hsync_q   <= ~HSYNC_POL;
      vsync_q   <= ~VSYNC_POL;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      rgb_q     <= rgb_d;
      blank_n_q <= active;
      hsync_q   <= hs_on ? HSYNC_POL : ~HSYNC_POL;
      vsync_q   <= vs_on ? VSYNC_POL : ~VSYNC_POL;
      err_q     <= err_d;
    end
  end

  assign ul1VgaClock   = ~ul1Clock;
  assign ul8VgaRed     = rgb_q[23:16];
  assign ul8VgaGreen   = rgb_q[15:8];
  assign ul8VgaBlue    = rgb_q[7:0];
  assign ul1VgaBlank_n = blank_n_q;
  assign ul1VgaHSync   = hsync_q;
  assign ul1VgaVSync   = vsync_q;
  assign ul1VgaSync_n  = 1'b0;
  assign ul1FrameErr   = err_q;

endmodule

// File: tb/tb_adv7123_vga_driver.sv
// Directed bench for adv7123_vga_driver on a shrunken 8x6 raster (4x3 active).
// Rows of {stimulus, expected ready/colour/error} are replayed cycle by cycle; raster outputs follow position.
module tb_adv7123_vga_driver;

  localparam int HA = 4, HFP = 1, HS = 2, HBP = 1;
  localparam int VA = 3, VFP = 1, VS = 1, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;

  localparam logic [1:0] R0 = 2'd0, R1 = 2'd1, RA = 2'd2;
  localparam logic       S0 = 1'b0, SA = 1'b1;

  typedef struct {
    int          n;
    logic        valid;
    logic        new_sof;
    logic        setd;
    logic [23:0] data;
    logic [1:0]  rmode;
    logic        smode;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic [23:0] pix_data = '0;
  logic        pix_sof = 1'b0;
  logic        ready, frame_err, vga_clk, blank_n, hsync, vsync, sync_n;
  logic [7:0]  red, green, blue;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          pos = 0;
  logic [23:0] src_data = '0;
  logic        src_sof = 1'b0;
  vec_t        tbl[18];

  always #5 clk = ~clk;

  adv7123_vga_driver #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .ul1Clock(clk),
    .ul1Reset_n(rst_n),
    .ul1PixValid(pix_valid),
    .ul24PixData(pix_data),
    .ul1PixSof(pix_sof),
    .ul1PixReady(ready),
    .ul1FrameErr(frame_err),
    .ul1VgaClock(vga_clk),
    .ul8VgaRed(red),
    .ul8VgaGreen(green),
    .ul8VgaBlue(blue),
    .ul1VgaBlank_n(blank_n),
    .ul1VgaHSync(hsync),
    .ul1VgaVSync(vsync),
    .ul1VgaSync_n(sync_n)
  );

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s pos=%0d t=%0t actual=%h required=%h", name, pos, $time, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rgb"}, {red, green, blue}, 24'd0);
    chk({tag, "_blank_n"}, blank_n, 1'b0);
    chk({tag, "_hsync"}, hsync, 1'b1);
    chk({tag, "_vsync"}, vsync, 1'b1);
    chk({tag, "_sync_n"}, sync_n, 1'b0);
    chk({tag, "_err"}, frame_err, 1'b0);
    chk({tag, "_ready"}, ready, 1'b0);
  endtask

  // Entered at a falling edge; drives one pixel slot and checks ready then the registered outputs.
  task automatic do_cycle(input logic v, input logic [1:0] rmode, input logic smode, input logic exp_err);
    int          h;
    int          ln;
    logic        act;
    logic        exp_rdy;
    logic [23:0] drove;
    h   = pos % HT;
    ln  = (pos / HT) % VT;
    act = (h < HA) && (ln < VA);
    exp_rdy = (rmode == R0) ? 1'b0 : (rmode == R1) ? 1'b1 : act;
    drove = src_data;
    pix_valid = v;
    pix_sof   = v & src_sof;
    pix_data  = drove;
    #1;
    chk("ready", ready, exp_rdy);
    @(posedge clk);
    #1;
    chk("rgb", {red, green, blue}, (smode == SA && act) ? drove : 24'd0);
    chk("blank_n", blank_n, act);
    chk("hsync", hsync, !((h >= HA + HFP) && (h <= HA + HFP + HS - 1)));
    chk("vsync", vsync, !((ln >= VA + VFP) && (ln <= VA + VFP + VS - 1)));
    chk("frame_err", frame_err, exp_err);
    chk("sync_n", sync_n, 1'b0);
    chk("vga_clk", vga_clk, 1'b0);
    if (v && exp_rdy) begin
      src_sof  = 1'b0;
      src_data = src_data + 24'h030507;
    end
    pos++;
    @(negedge clk);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      if (tbl[i].setd) src_data = tbl[i].data;
      if (tbl[i].new_sof) src_sof = 1'b1;
      for (int k = 0; k < tbl[i].n; k++)
        do_cycle(tbl[i].valid, tbl[i].rmode, tbl[i].smode, tbl[i].err && (k == 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    //               n  vld sof setd data        ready smode err
    tbl[0]  = '{40, 1'b0, 1'b0, 1'b0, 24'h000000, R0, S0, 1'b0}; // idle raster
    tbl[1]  = '{ 8, 1'b1, 1'b0, 1'b1, 24'hAA0000, R1, S0, 1'b0}; // non-SOF pixels discarded
    tbl[2]  = '{48, 1'b1, 1'b1, 1'b1, 24'h010203, RA, SA, 1'b0}; // lock on SOF, stream frame
    tbl[3]  = '{48, 1'b1, 1'b1, 1'b0, 24'h000000, RA, SA, 1'b0}; // second frame re-locks
    tbl[4]  = '{ 9, 1'b1, 1'b1, 1'b0, 24'h000000, RA, SA, 1'b0}; // up to (0,1)
    tbl[5]  = '{ 1, 1'b0, 1'b0, 1'b0, 24'h000000, R1, S0, 1'b1}; // underrun at (1,1)
    tbl[6]  = '{38, 1'b1, 1'b0, 1'b0, 24'h000000, R1, S0, 1'b0}; // rest of frame black
    tbl[7]  = '{48, 1'b1, 1'b1, 1'b0, 24'h000000, RA, SA, 1'b0}; // resumes at next frame
    tbl[8]  = '{ 2, 1'b1, 1'b1, 1'b0, 24'h000000, RA, SA, 1'b0}; // (0,0),(1,0)
    tbl[9]  = '{ 1, 1'b1, 1'b1, 1'b0, 24'h000000, R0, S0, 1'b1}; // misplaced SOF at (2,0)
    tbl[10] = '{45, 1'b1, 1'b0, 1'b0, 24'h000000, R0, S0, 1'b0}; // SOF pixel held
    tbl[11] = '{48, 1'b1, 1'b0, 1'b0, 24'h000000, RA, SA, 1'b0}; // held SOF shown at (0,0)
    tbl[12] = '{ 1, 1'b1, 1'b0, 1'b0, 24'h000000, R0, S0, 1'b1}; // non-SOF at first pixel
    tbl[13] = '{47, 1'b0, 1'b0, 1'b0, 24'h000000, R0, S0, 1'b0}; // waiting, no source
    tbl[14] = '{48, 1'b1, 1'b1, 1'b1, 24'h400000, RA, SA, 1'b0}; // stream
    tbl[15] = '{20, 1'b1, 1'b1, 1'b0, 24'h000000, RA, SA, 1'b0}; // stream to (3,2)
    tbl[16] = '{48, 1'b1, 1'b0, 1'b0, 24'h000000, R1, S0, 1'b0}; // after reset: waits for SOF
    tbl[17] = '{48, 1'b1, 1'b1, 1'b0, 24'h000000, RA, SA, 1'b0}; // relock after reset

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    pos   = 0;

    run_rows(0, 16);

    // Asynchronous reset mid-frame: outputs drop to reset values without a clock edge.
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk_reset_outputs("rst_async");
    @(posedge clk);
    #1;
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    pos   = 0;

    run_rows(16, 18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
